// File: rtl/ram_block_copy.sv
// rtl/ram_block_copy.sv - pipelined block-copy engine driving a dual-port synchronous RAM
//
// Reads a source window through RAM port A and writes it to a destination window
// through RAM port B, one word per clock. The read of word k and the write of
// word k-1 share a cycle; din_b is the RAM's registered read data passed straight through.
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   start                     request, sampled only while idle
//   src_addr, dst_addr, len   transfer window, captured on an accepted start
//   busy, done, ovl_err       status: in progress, one-cycle end pulse, sticky overlap refusal
//   cs                        RAM chip select (active-low), low while busy
//   addr_a, oe_a, we_a        RAM port A (read side); we_a tied low
//   rd_data                   RAM port A registered read data
//   addr_b, din_b, we_b, oe_b RAM port B (write side); oe_b tied low
//   checksum                  XOR of words written in the current transfer
//
// Optional feature macro: BLOCK_COPY_CHECKSUM_EN builds the checksum accumulator;
// without it checksum is tied to zero.

module ram_block_copy #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  ovl_err,
    output logic                  cs,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic                  oe_a,
    output logic                  we_a,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] din_b,
    output logic                  we_b,
    output logic                  oe_b,
    output logic [DATA_WIDTH-1:0] checksum
);

    // Wide enough to hold src+len without wrapping.
    localparam int CW = ((ADDR_WIDTH > LEN_WIDTH) ? ADDR_WIDTH : LEN_WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic [ADDR_WIDTH-1:0] r_addr_a;
    logic [ADDR_WIDTH-1:0] r_addr_b;
    logic [ADDR_WIDTH-1:0] r_offset;
    logic [LEN_WIDTH-1:0]  r_remain;
    logic                  r_oe_a;
    logic                  r_we_b;
    logic                  r_ovl_err;

    logic [CW-1:0]         w_src_ext;
    logic [CW-1:0]         w_dst_ext;
    logic [CW-1:0]         w_end_ext;
    logic                  w_overlap;
    logic                  w_start_idle;
    logic                  w_go;
    logic                  w_last;

    // A forward copy into a destination that starts inside the source window
    // would overwrite words before they are read, so such requests are refused.
    assign w_src_ext    = CW'(src_addr);
    assign w_dst_ext    = CW'(dst_addr);
    assign w_end_ext    = w_src_ext + CW'(len);
    assign w_overlap    = (w_src_ext < w_dst_ext) && (w_dst_ext < w_end_ext);

    assign w_start_idle = (r_state == S_IDLE) && start;
    assign w_go         = w_start_idle && (len != '0) && !w_overlap;
    assign w_last       = (r_remain == LEN_WIDTH'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_go ? S_RUN : S_FIN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_a  <= '0;
            r_addr_b  <= '0;
            r_offset  <= '0;
            r_remain  <= '0;
            r_oe_a    <= 1'b0;
            r_we_b    <= 1'b0;
            r_ovl_err <= 1'b0;
        end else begin
            // Write stage trails the read stage by exactly one cycle.
            r_we_b <= r_oe_a;
            if (r_oe_a) begin
                r_addr_b <= r_addr_a + r_offset;
            end

            if (w_start_idle) begin
                r_ovl_err <= w_overlap;
            end

            if (w_go) begin
                r_oe_a   <= 1'b1;
                r_addr_a <= src_addr;
                r_offset <= dst_addr - src_addr;
                r_remain <= len;
            end else if (r_state == S_RUN) begin
                if (w_last) begin
                    r_oe_a <= 1'b0;
                end else begin
                    r_addr_a <= r_addr_a + ADDR_WIDTH'(1);
                    r_remain <= r_remain - LEN_WIDTH'(1);
                end
            end
        end
    end

`ifdef BLOCK_COPY_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_checksum;

    // A refused request leaves the previous transfer's checksum in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_start_idle && !w_overlap) begin
            r_checksum <= '0;
        end else if (r_we_b) begin
            r_checksum <= r_checksum ^ rd_data;
        end
    end

    assign checksum = r_checksum;
`else
    assign checksum = '0;
`endif

    assign busy    = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done    = (r_state == S_FIN);
    assign cs      = !busy;
    assign ovl_err = r_ovl_err;
    assign addr_a  = r_addr_a;
    assign oe_a    = r_oe_a;
    assign we_a    = 1'b0;
    assign addr_b  = r_addr_b;
    assign din_b   = rd_data;
    assign we_b    = r_we_b;
    assign oe_b    = 1'b0;

endmodule

// File: tb/tb_ram_block_copy.sv
// tb/tb_ram_block_copy.sv - scoreboard bench for ram_block_copy with a behavioural RAM

module tb_ram_block_copy;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        ovl_err;
    logic        cs;
    logic [15:0] addr_a;
    logic        oe_a;
    logic        we_a;
    logic [7:0]  rd_data;
    logic [15:0] addr_b;
    logic [7:0]  din_b;
    logic        we_b;
    logic        oe_b;
    logic [7:0]  checksum;

    ram_block_copy #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .LEN_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .len(len), .busy(busy), .done(done), .ovl_err(ovl_err), .cs(cs),
        .addr_a(addr_a), .oe_a(oe_a), .we_a(we_a), .rd_data(rd_data),
        .addr_b(addr_b), .din_b(din_b), .we_b(we_b), .oe_b(oe_b), .checksum(checksum)
    );

    always #5 clk = ~clk;

`ifdef BLOCK_COPY_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    typedef struct packed {
        int          cyc;
        logic [15:0] addr;
        logic [7:0]  data;
    } acc_t;

    typedef struct packed {
        int         cyc;
        logic       ovl;
        logic [7:0] ck;
    } done_t;

    acc_t  exp_rd[$];
    acc_t  exp_wr[$];
    done_t exp_done[$];

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    logic [7:0] ram_mem [0:65535];
    bit         ram_vld [0:65535];
    logic [7:0] refmem  [0:65535];
    logic       pl_we = 1'b0;
    logic [15:0] pl_addr = '0;
    logic [7:0]  pl_data = '0;

    logic       model_ovl = 1'b0;
    logic [7:0] model_ck  = '0;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ {a[14:8], a[15]} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [15:0] a);
        return ram_vld[a] ? ram_mem[a] : init_val(a);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural dual-port RAM: registered read on A, write on B.
    always @(posedge clk) begin
        if (pl_we) begin
            ram_mem[pl_addr] <= pl_data;
            ram_vld[pl_addr] <= 1'b1;
        end
        if (!cs && oe_a) rd_data <= ram_rd(addr_a);
        if (!cs && we_b) begin
            ram_mem[addr_b] <= din_b;
            ram_vld[addr_b] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_fail(input string nm, input logic [31:0] act);
        tests++;
        failed++;
        $display("FAIL %s: got %0h expected nothing (cycle %0d)", nm, act, cyc);
    endtask

    acc_t  m_a;
    done_t m_d;

    always @(negedge clk) begin : monitor
        if (!rst) begin
            if (oe_a) begin
                if (exp_rd.size() == 0) chk_fail("unexpected_read", {16'h0, addr_a});
                else begin
                    m_a = exp_rd.pop_front();
                    chk("rd_addr", {16'h0, addr_a}, {16'h0, m_a.addr});
                    chk("rd_cycle", cyc, m_a.cyc);
                    chk("rd_cs", {31'h0, cs}, 32'h0);
                end
            end
            if (we_b) begin
                if (exp_wr.size() == 0) chk_fail("unexpected_write", {16'h0, addr_b});
                else begin
                    m_a = exp_wr.pop_front();
                    chk("wr_addr", {16'h0, addr_b}, {16'h0, m_a.addr});
                    chk("wr_data", {24'h0, din_b}, {24'h0, m_a.data});
                    chk("wr_cycle", cyc, m_a.cyc);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) chk_fail("unexpected_done", 32'h1);
                else begin
                    m_d = exp_done.pop_front();
                    chk("done_cycle", cyc, m_d.cyc);
                    chk("done_ovl_err", {31'h0, ovl_err}, {31'h0, m_d.ovl});
                    chk("done_checksum", {24'h0, checksum}, {24'h0, m_d.ck});
                    chk("done_busy_cs", {30'h0, busy, cs}, 32'h1);
                end
            end
        end
    end

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        refmem[a] = d;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
        chk({tag, "_done"}, {31'h0, done}, 32'h0);
        chk({tag, "_ovl_err"}, {31'h0, ovl_err}, 32'h0);
        chk({tag, "_cs"}, {31'h0, cs}, 32'h1);
        chk({tag, "_oe_a"}, {31'h0, oe_a}, 32'h0);
        chk({tag, "_we_b"}, {31'h0, we_b}, 32'h0);
        chk({tag, "_addr_a"}, {16'h0, addr_a}, 32'h0);
        chk({tag, "_addr_b"}, {16'h0, addr_b}, 32'h0);
        chk({tag, "_checksum"}, {24'h0, checksum}, 32'h0);
        chk({tag, "_we_a_oe_b"}, {30'h0, we_a, oe_b}, 32'h0);
    endtask

    // poke: cycle in which a stray start is raised; rc: cycle in which reset hits (0 = none)
    task automatic do_copy(input logic [15:0] s, input logic [15:0] d, input int n,
                           input int poke, input int rc);
        int         c0;
        int         busy_n;
        int         mm;
        bit         got;
        logic       ovl;
        logic [7:0] ck;
        logic [7:0] snap[$];
        acc_t       a;
        done_t      dn;
        int         keep;
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = 16'(n);
        c0  = cyc;
        ovl = (int'(s) < int'(d)) && (int'(d) < int'(s) + n);
        ck  = '0;
        snap.delete();
        if (!ovl) begin
            for (int k = 0; k < n; k++) begin
                snap.push_back(refmem[16'(s + 16'(k))]);
                ck ^= snap[k];
                a.cyc = c0 + 1 + k; a.addr = s + 16'(k); a.data = '0;
                exp_rd.push_back(a);
                a.cyc = c0 + 2 + k; a.addr = d + 16'(k); a.data = snap[k];
                exp_wr.push_back(a);
            end
            keep = (rc != 0) ? rc - 2 : n;
            for (int k = 0; k < keep; k++) refmem[16'(d + 16'(k))] = snap[k];
            if (CK_EN) model_ck = ck;
        end
        model_ovl = ovl;
        if (rc == 0) begin
            dn.cyc = (ovl || n == 0) ? c0 + 1 : c0 + n + 2;
            dn.ovl = model_ovl;
            dn.ck  = model_ck;
            exp_done.push_back(dn);
        end
        @(negedge clk);
        start = 1'b0;
        src_addr = 16'($urandom); dst_addr = 16'($urandom); len = 16'($urandom_range(1, 20));
        busy_n = 0;
        got = 1'b0;
        for (int t = 1; t <= n + 8; t++) begin
            if (busy) busy_n++;
            if (t == poke) begin
                start = 1'b1; src_addr = 16'($urandom); dst_addr = 16'($urandom);
            end
            if (t == poke + 1) start = 1'b0;
            if (t == rc) begin
                #2 rst = 1'b1;
                #1 check_reset_outputs("midreset");
                exp_rd.delete(); exp_wr.delete(); exp_done.delete();
                model_ovl = 1'b0; model_ck = '0;
                @(negedge clk);
                rst = 1'b0;
                got = 1'b1;
                break;
            end
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (!got) chk_fail("done_timeout", {16'h0, s});
        if (rc == 0) begin
            chk("busy_cycles", busy_n, (ovl || n == 0) ? 0 : n + 1);
            mm = 0;
            for (int k = 0; k < n; k++)
                if (ram_rd(16'(d + 16'(k))) !== refmem[16'(d + 16'(k))]) mm++;
            chk("dst_window_mismatches", mm, 0);
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int          n;
        int          mode;
        int          poke;
        int          rc;
        int          mm;
        logic [15:0] s;
        logic [15:0] d;
        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        for (int i = 0; i < 65536; i++) refmem[i] = init_val(16'(i));
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        preload(16'h0010, 8'hA1); preload(16'h0011, 8'hB2);
        preload(16'h0012, 8'hC3); preload(16'h0013, 8'hD4);
        do_copy(16'h0010, 16'h0040, 4, 0, 0);
        chk("t1_checksum", {24'h0, checksum}, CK_EN ? 32'h04 : 32'h0);
        do_copy(16'h0005, 16'h0009, 0, 0, 0);
        do_copy(16'h0020, 16'h0022, 4, 0, 0);
        chk("t3_ovl_sticky", {31'h0, ovl_err}, 32'h1);
        do_copy(16'h0022, 16'h0020, 4, 0, 0);
        do_copy(16'hFFFE, 16'h0100, 4, 0, 0);
        do_copy(16'h0300, 16'h0500, 8, 2, 0);
        do_copy(16'h0600, 16'h0700, 8, 0, 3);
        do_copy(16'h0600, 16'h0700, 8, 0, 0);
        do_copy(16'h0800, 16'h0800, 5, 0, 0);

        for (int i = 0; i < 40; i++) begin
            n    = $urandom_range(0, 12);
            s    = 16'($urandom);
            mode = $urandom_range(0, 3);
            poke = 0;
            rc   = 0;
            case (mode)
                0: d = s + 16'(n) + 16'($urandom_range(0, 500));
                1: d = s - 16'(n) - 16'($urandom_range(0, 500));
                2: d = s;
                default: begin
                    if (n >= 2) begin
                        s = 16'($urandom_range(0, 16'hFF00));
                        d = s + 16'($urandom_range(1, n - 1));
                    end else begin
                        d = s + 16'(n + 3);
                    end
                end
            endcase
            if (mode != 3 && n >= 1 && (i % 10) == 3) poke = $urandom_range(1, n);
            if (mode != 3 && n >= 1 && (i % 10) == 7) rc = $urandom_range(2, n + 1);
            do_copy(s, d, n, poke, rc);
        end

        repeat (2) @(negedge clk);
        mm = 0;
        for (int i = 0; i < 65536; i++)
            if (ram_rd(16'(i)) !== refmem[i]) mm++;
        chk("ram_final_mismatches", mm, 0);
        chk("leftover_expectations", exp_rd.size() + exp_wr.size() + exp_done.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
